// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with hardwired-zero register, write bypass and busy scoreboard
module register_file_mp #(
    parameter int BITSIZE  = 64,
    parameter int REGSIZE  = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 2,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(REGSIZE),
    localparam int CW      = $clog2(REGSIZE + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREAD*AW-1:0]       ReadSelect,
    output logic [NREAD*BITSIZE-1:0]  ReadData,
    output logic [NREAD-1:0]          ReadBusy,
    input  logic [NWRITE-1:0]         WriteEnable,
    input  logic [NWRITE*AW-1:0]      WriteSelect,
    input  logic [NWRITE*BITSIZE-1:0] WriteData,
    input  logic                      ReserveEnable,
    input  logic [AW-1:0]             ReserveSelect,
    output logic [CW-1:0]             BusyCount
);

    logic [BITSIZE-1:0] regs   [REGSIZE];
    logic [BITSIZE-1:0] wr_val [REGSIZE];
    logic [REGSIZE-1:0] busy;
    logic [REGSIZE-1:0] busy_next;
    logic [REGSIZE-1:0] wr_hit;
    logic [REGSIZE-1:0] rsv_hit;
    logic [CW-1:0]      busy_count;
    logic [CW-1:0]      set_cnt;
    logic [CW-1:0]      clr_cnt;

    // Ports are scanned in ascending order so the highest-index writer wins.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < REGSIZE; r++) begin
            wr_val[r] = '0;
            for (int p = 0; p < NWRITE; p++) begin
                if (WriteEnable[p] && (WriteSelect[p*AW +: AW] == AW'(r))) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = WriteData[p*BITSIZE +: BITSIZE];
                end
            end
        end
        wr_hit[ZERO_REG] = 1'b0;
    end

    always_comb begin
        rsv_hit = '0;
        if (ReserveEnable && (ReserveSelect != AW'(ZERO_REG))) begin
            rsv_hit[ReserveSelect] = 1'b1;
        end
    end

    // A reserve overrides a completing write: the new producer owns the register.
    assign busy_next = (busy & ~wr_hit) | rsv_hit;

    always_comb begin
        set_cnt = '0;
        clr_cnt = '0;
        for (int r = 0; r < REGSIZE; r++) begin
            if (!busy[r] && busy_next[r]) begin
                set_cnt = set_cnt + CW'(1);
            end
            if (busy[r] && !busy_next[r]) begin
                clr_cnt = clr_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REGSIZE; r++) begin
                regs[r] <= '0;
            end
            busy       <= '0;
            busy_count <= '0;
        end else begin
            for (int r = 0; r < REGSIZE; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_val[r];
                end
            end
            busy       <= busy_next;
            busy_count <= busy_count + set_cnt - clr_cnt;
        end
    end

    assign BusyCount = busy_count;

    for (genvar q = 0; q < NREAD; q++) begin : g_read
        logic [AW-1:0] sel;
        assign sel = ReadSelect[q*AW +: AW];

        always_comb begin
            ReadData[q*BITSIZE +: BITSIZE] = regs[sel];
            ReadBusy[q]                    = busy[sel];
            if (sel == AW'(ZERO_REG)) begin
                ReadData[q*BITSIZE +: BITSIZE] = '0;
                ReadBusy[q]                    = 1'b0;
            end else if ((BYPASS != 0) && wr_hit[sel]) begin
                ReadData[q*BITSIZE +: BITSIZE] = wr_val[sel];
                ReadBusy[q]                    = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - directed bench for register_file_mp, bypassed and unbypassed instances
module tb_register_file_mp;

    logic         clk = 1'b0;
    logic         rst;
    logic [9:0]   rsel;
    logic [1:0]   wen;
    logic [9:0]   wsel;
    logic [127:0] wdata;
    logic         ren;
    logic [4:0]   rvsel;
    logic [127:0] rd_b, rd_n;
    logic [1:0]   rb_b, rb_n;
    logic [5:0]   cnt_b, cnt_n;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    register_file_mp #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .ReadSelect(rsel), .ReadData(rd_b), .ReadBusy(rb_b),
        .WriteEnable(wen), .WriteSelect(wsel), .WriteData(wdata),
        .ReserveEnable(ren), .ReserveSelect(rvsel), .BusyCount(cnt_b)
    );

    register_file_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .ReadSelect(rsel), .ReadData(rd_n), .ReadBusy(rb_n),
        .WriteEnable(wen), .WriteSelect(wsel), .WriteData(wdata),
        .ReserveEnable(ren), .ReserveSelect(rvsel), .BusyCount(cnt_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        wen = 2'b00;
        ren = 1'b0;
        rst = 1'b0;
    endtask

    task automatic set_reads(input logic [4:0] a, input logic [4:0] b);
        rsel = {b, a};
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        set_reads(5'd0, 5'd5);
        total++; if (rd_b !== 128'd0) begin bad++; $display("FAIL reset_data_r0_r5 got=%h exp=0", rd_b); end
        total++; if (rb_b !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b exp=00", rb_b); end
        total++; if (cnt_b !== 6'd0 || cnt_n !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d/%0d exp=0", cnt_b, cnt_n); end
        set_reads(5'd30, 5'd30);
        total++; if (rd_n !== 128'd0 || rb_n !== 2'b00) begin bad++; $display("FAIL reset_r30 got=%h/%b exp=0/00", rd_n, rb_n); end
    endtask

    task automatic test_write_no_bypass();
        wen = 2'b01; wsel = {5'd0, 5'd3}; wdata = {64'd0, 64'hDEADBEEF};
        set_reads(5'd3, 5'd3);
        total++; if (rd_n[63:0] !== 64'd0) begin bad++; $display("FAIL nobyp_same_cycle got=%h exp=0", rd_n[63:0]); end
        total++; if (rd_b[127:64] !== 64'hDEADBEEF) begin bad++; $display("FAIL byp_same_cycle got=%h exp=deadbeef", rd_b[127:64]); end
        tick();
        set_reads(5'd3, 5'd3);
        total++; if (rd_n[63:0] !== 64'hDEADBEEF) begin bad++; $display("FAIL nobyp_next_cycle got=%h exp=deadbeef", rd_n[63:0]); end
    endtask

    task automatic test_conflict();
        wen = 2'b11; wsel = {5'd7, 5'd7}; wdata = {64'h22, 64'h11};
        set_reads(5'd0, 5'd7);
        total++; if (rd_b[127:64] !== 64'h22) begin bad++; $display("FAIL conflict_bypass got=%h exp=22", rd_b[127:64]); end
        total++; if (rd_n[127:64] !== 64'h0) begin bad++; $display("FAIL conflict_nobyp_old got=%h exp=0", rd_n[127:64]); end
        tick();
        set_reads(5'd7, 5'd7);
        total++; if (rd_b[63:0] !== 64'h22 || rd_n[63:0] !== 64'h22) begin bad++; $display("FAIL conflict_stored got=%h/%h exp=22", rd_b[63:0], rd_n[63:0]); end
    endtask

    task automatic test_zero_reg();
        wen = 2'b01; wsel = {5'd0, 5'd31}; wdata = {64'd0, 64'hFFFF};
        ren = 1'b1; rvsel = 5'd31;
        set_reads(5'd31, 5'd31);
        total++; if (rd_b !== 128'd0 || rb_b !== 2'b00) begin bad++; $display("FAIL zero_same_cycle got=%h/%b exp=0/00", rd_b, rb_b); end
        tick();
        set_reads(5'd31, 5'd31);
        total++; if (rd_n !== 128'd0 || rb_n !== 2'b00) begin bad++; $display("FAIL zero_after got=%h/%b exp=0/00", rd_n, rb_n); end
        total++; if (cnt_b !== 6'd0) begin bad++; $display("FAIL zero_count got=%0d exp=0", cnt_b); end
    endtask

    task automatic test_scoreboard();
        ren = 1'b1; rvsel = 5'd4;
        tick();
        set_reads(5'd4, 5'd4);
        total++; if (rb_b !== 2'b11 || cnt_b !== 6'd1) begin bad++; $display("FAIL reserve_r4 got=%b/%0d exp=11/1", rb_b, cnt_b); end
        ren = 1'b1; rvsel = 5'd4;
        tick();
        total++; if (cnt_b !== 6'd1) begin bad++; $display("FAIL reserve_again got=%0d exp=1", cnt_b); end
        ren = 1'b1; rvsel = 5'd4; wen = 2'b10; wsel = {5'd4, 5'd0}; wdata = {64'hABCD, 64'd0};
        set_reads(5'd4, 5'd4);
        total++; if (rb_b !== 2'b00 || rb_n !== 2'b11) begin bad++; $display("FAIL busy_bypass got=%b/%b exp=00/11", rb_b, rb_n); end
        tick();
        set_reads(5'd4, 5'd4);
        total++; if (rb_n !== 2'b11 || cnt_n !== 6'd1) begin bad++; $display("FAIL reserve_wins got=%b/%0d exp=11/1", rb_n, cnt_n); end
        total++; if (rd_n[63:0] !== 64'hABCD) begin bad++; $display("FAIL reserve_write_data got=%h exp=abcd", rd_n[63:0]); end
        wen = 2'b01; wsel = {5'd0, 5'd4}; wdata = {64'd0, 64'h55};
        tick();
        set_reads(5'd4, 5'd4);
        total++; if (rb_b !== 2'b00 || cnt_b !== 6'd0 || rd_b[63:0] !== 64'h55) begin bad++; $display("FAIL write_clears got=%b/%0d/%h exp=00/0/55", rb_b, cnt_b, rd_b[63:0]); end
        wen = 2'b01; wsel = {5'd0, 5'd4}; wdata = {64'd0, 64'h66};
        tick();
        total++; if (cnt_b !== 6'd0) begin bad++; $display("FAIL write_nonbusy_no_underflow got=%0d exp=0", cnt_b); end
    endtask

    task automatic test_back_to_back();
        wen = 2'b11; wsel = {5'd9, 5'd8}; wdata = {64'hBBBB_0000_0000_0009, 64'hAAAA_0000_0000_0008};
        tick();
        set_reads(5'd8, 5'd9);
        total++; if (rd_n !== {64'hBBBB_0000_0000_0009, 64'hAAAA_0000_0000_0008}) begin bad++; $display("FAIL dual_write_read got=%h", rd_n); end
        ren = 1'b1; rvsel = 5'd1; wen = 2'b01; wsel = {5'd0, 5'd8}; wdata = {64'd0, 64'h88};
        tick();
        ren = 1'b1; rvsel = 5'd2;
        tick();
        ren = 1'b1; rvsel = 5'd3;
        tick();
        set_reads(5'd1, 5'd3);
        total++; if (cnt_b !== 6'd3 || rb_b !== 2'b11) begin bad++; $display("FAIL three_reserved got=%0d/%b exp=3/11", cnt_b, rb_b); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; ren = 1'b1; rvsel = 5'd10; wen = 2'b01; wsel = {5'd0, 5'd9}; wdata = {64'd0, 64'h99};
        tick();
        set_reads(5'd9, 5'd10);
        total++; if (cnt_b !== 6'd0 || cnt_n !== 6'd0) begin bad++; $display("FAIL mid_reset_count got=%0d/%0d exp=0", cnt_b, cnt_n); end
        total++; if (rd_b !== 128'd0 || rb_b !== 2'b00) begin bad++; $display("FAIL mid_reset_lost got=%h/%b exp=0/00", rd_b, rb_b); end
        set_reads(5'd1, 5'd8);
        total++; if (rb_n !== 2'b00 || rd_n !== 128'd0) begin bad++; $display("FAIL mid_reset_cleared got=%h/%b exp=0/00", rd_n, rb_n); end
    endtask

    initial begin
        rst = 1'b1; rsel = '0; wen = '0; wsel = '0; wdata = '0; ren = 1'b0; rvsel = '0;
        @(posedge clk);
        test_reset();
        test_write_no_bypass();
        test_conflict();
        test_zero_reg();
        test_scoreboard();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file for the pipelined ARM datapath. It provides NREAD asynchronous read ports and NWRITE synchronous write ports, with a configurable hardwired-zero register and optional same-cycle write-to-read bypass. A per-register scoreboard of busy bits lets issue logic detect read-after-write hazards on in-flight destinations. It replaces the single-cycle 2R/1W register file between decode (reads, reserve) and writeback (writes).

## Interface
- BITSIZE, 64, data width of each register
- REGSIZE, 32, number of registers; AW = $clog2(REGSIZE)
- NREAD, 2, number of read ports
- NWRITE, 2, number of write ports
- ZERO_REG, 31, index of the hardwired-zero register
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = no forwarding
- Ports are packed, with port p occupying slice [p*W +: W].
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- ReadSelect  in  NREAD*AW  register index per read port
- ReadData  out  NREAD*BITSIZE  read value per port (combinational)
- ReadBusy  out  NREAD  1 = selected register has an outstanding producer
- WriteEnable  in  NWRITE  per-port write strobe
- WriteSelect  in  NWRITE*AW  destination index per write port
- WriteData  in  NWRITE*BITSIZE  write value per port
- ReserveEnable  in  1  mark ReserveSelect busy (instruction issued)
- ReserveSelect  in  AW  destination register being reserved
- BusyCount  out  $clog2(REGSIZE+1)  number of busy registers

## Operation
- Storage: REGSIZE x BITSIZE registers, plus a busy[REGSIZE] bit vector and a BusyCount register.
- Reset: on a rising edge with rst=1, all registers go to 0, all busy bits to 0, and BusyCount to 0. rst overrides any write or reserve in the same cycle.
- Write:
  - Each enabled port p with WriteSelect[p] != ZERO_REG writes WriteData[p] at the edge.
  - If several ports target the same register in one cycle, the highest-index port wins.
  - Writes to ZERO_REG are discarded.
- Read, per port:
  - If ReadSelect == ZERO_REG: ReadData = 0 and ReadBusy = 0.
  - Else, if BYPASS=1 and some enabled write port targets ReadSelect this cycle: ReadData = that port's WriteData (highest index wins) and ReadBusy = 0.
  - Otherwise: ReadData = stored value and ReadBusy = busy[ReadSelect].
- Scoreboard:
  - busy[r] clears at the edge when any enabled write targets r.
  - busy[r] sets at the edge when ReserveEnable=1, ReserveSelect = r, and r != ZERO_REG.
  - Reserve and write to the same r in the same cycle: reserve wins, so busy stays 1 (the new producer supersedes).
  - Reserve of an already-busy r: busy stays 1, no count change.
  - Write to a non-busy r: data is written, busy is unchanged.
- BusyCount: always equals popcount(busy). It is updated incrementally as +1 per 0->1 transition and -1 per 1->0 transition. It must never underflow and never exceed REGSIZE-1 (ZERO_REG can never be busy).

## Timing
- Read latency is 0 cycles (combinational from ReadSelect, the stored state, and the same-cycle write inputs when BYPASS=1).
- Write latency is 1 cycle. With BYPASS=0, the new value is visible on reads in the cycle after the edge.
- Busy set and clear take effect at the edge. ReadBusy reflects the new busy state in the following cycle.
- Reset values: ReadData = 0 for every select, ReadBusy = 0, BusyCount = 0. These hold from the first cycle after the reset edge.
- Reset in mid-operation, with outstanding reservations, clears all busy bits and BusyCount in one edge. Writes and reserves presented in that cycle are lost.
- Before the first reset, register and busy contents are undefined. The bench must apply rst before checking anything.

## Test plan
- Reset then read: assert rst for 1 cycle, then read r0, r5, r30 on both ports -> ReadData = 0, ReadBusy = 0, BusyCount = 0.
- Write/read, BYPASS=0: write 0xDEADBEEF to r3 via port 0 -> same-cycle read of r3 returns the old value 0; the next cycle returns 0xDEADBEEF.
- Bypass and write conflict, BYPASS=1: port 0 writes 0x11 and port 1 writes 0x22 to r7 in the same cycle -> same-cycle read of r7 = 0x22; stored r7 = 0x22 afterwards.
- Zero register: write 0xFFFF to r31 and reserve r31 -> reading r31 returns 0, ReadBusy = 0, BusyCount unchanged.
- Scoreboard:
  - Reserve r4 -> next cycle ReadBusy = 1 and BusyCount = 1.
  - Write r4 while reserving r4 -> still busy, BusyCount = 1.
  - Write r4 alone -> busy clears, BusyCount = 0.
  - Reserve r1, r2, r3 then assert rst -> BusyCount = 0.
